rv_decode_exec: RTL and testbench
=================================

// Module: rv_decode_exec
// PURPOSE
//  Decode + execute slice of the multicycle RV32I subset datapath (lw, sw, sub, xor, addi, srl, beq).
//  Registers instruction fields and immediate from the fetched word, then computes the ALU result.
//  Also computes the beq compare and PC-select; results feed data memory, register writeback and PC adder.
//  Register file and control unit are external: the control unit supplies alucontrol, alusrc and branch.
// PARAMETERS
//  XLEN   32  datapath width
//  IMM_W  12  stored immediate width
// PORTS
//  clk         in   1   single system clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  instrucao   in   32  instruction word from fetch
//  readdata1R  in   32  register file read data for rs1
//  readdata2R  in   32  register file read data for rs2
//  alucontrol  in   4   ALU operation select from control unit
//  alusrc      in   1   1 = operand B is the sign-extended immediate, 0 = readdata2R
//  branch      in   1   instruction is beq
//  opcode      out  7   instr[6:0]
//  rd          out  5   instr[11:7]
//  rs1         out  5   instr[19:15]
//  rs2         out  5   instr[24:20]
//  funct3      out  3   instr[14:12]
//  funct7      out  7   instr[31:25]
//  immediate   out  12  decoded immediate (format-dependent)
//  tipo        out  3   instruction class
//  aluresult1  out  32  compare value, readdata1R - readdata2R
//  aluresult2  out  32  main ALU result (address or writeback data)
//  pcsrc       out  1   1 = take branch
// BEHAVIOUR
//  Clock and reset
//  - One clock; asynchronous, active-low reset (rst_n).
//  - In reset: every output is 0, except tipo = 3'b111.
//  Decode stage
//  - At posedge, instrucao is registered into all field outputs. Latency 1 cycle.
//  - tipo encoding by opcode:
//      0110011 -> 000 (R)
//      0010011 -> 001 (I-ALU)
//      0000011 -> 010 (load)
//      0100011 -> 011 (S)
//      1100011 -> 100 (B)
//      any other opcode -> 111; immediate = 0
//  - immediate by format:
//      I/load: instr[31:20]
//      S: {instr[31:25], instr[11:7]}
//      B: {instr[31], instr[7], instr[30:25], instr[11:8]} (offset bits 12:1, bit 0 implied 0)
//      R: 0
//  Execute stage
//  - At the posedge after decode, operands are sampled and results registered. Latency 1 cycle.
//  - Execute uses the registered immediate; instrucao -> aluresult is therefore 2 cycles.
//  - Operand A = readdata1R.
//  - Operand B = alusrc ? {{20{immediate[11]}}, immediate} : readdata2R.
//  - alucontrol:
//      0000 ADD   0001 SUB   0010 XOR   0011 SRL (logical, B[4:0])
//      0100 AND   0101 OR    0110 SLL (B[4:0])   0111 SLT (signed, 1/0)
//      1xxx -> result 0
//  - Arithmetic is mod 2^32, with no overflow flag.
//  - SRL/SLL by 0 pass A unchanged; the shift amount uses only B[4:0], so shifting by 32 acts as a shift by 0.
//  - aluresult1 = readdata1R - readdata2R, every cycle, independent of alucontrol.
//  - pcsrc = branch & (readdata1R == readdata2R), registered with the results; branch = 0 forces pcsrc = 0.
//  Boundary cases
//  - rst_n asserted mid-operation clears both stages immediately; the first valid result needs 2 edges after release.
//  - Both stages update on every edge; there is no stall or enable.
// STRUCTURE
//  - Shared package: opcode constants, tipo codes, alucontrol codes, XLEN.
//  - One natural sub-module, rv_alu_core: combinational operand mux, ALU and compare.
//    The top module holds both register stages.
// TESTING
//  Bench clock: 10-time-unit period (5 high, 5 low); rst_n low for 2 cycles, then high.
//  1. sub x3,x1,x2 = 0x402081B3, alucontrol=0001, alusrc=0, rd1=10, rd2=3
//     -> tipo=000, rd=3, rs1=1, rs2=2, funct7=0x20; aluresult2=7.
//  2. addi x5,x0,-1 = 0xFFF00293, alusrc=1, ADD, rd1=0
//     -> tipo=001, immediate=0xFFF, aluresult2=0xFFFFFFFF.
//  3. sw x2,4(x1) = 0x0020A223, ADD, alusrc=1, rd1=0x100
//     -> tipo=011, immediate=0x004, aluresult2=0x104.
//  4. beq x1,x2,+8 = 0x00208463, branch=1, SUB, rd1=rd2=5
//     -> tipo=100, immediate=0x004, aluresult1=0, pcsrc=1; repeat with rd2=6 -> pcsrc=0.
//  5. srl x4,x1,x2 = 0x0020D233, alucontrol=0011, rd1=0x80000000, rd2=31 -> aluresult2=1.
//     xor with rd1=0xF0F0, rd2=0xFFFF -> 0x0F0F.
//  6. Drop rst_n mid-stream -> all outputs 0, tipo=111 immediately; undefined opcode 0x0000007F -> tipo=111, immediate=0.

Source files
------------

// File: rtl/rv_decode_exec_pkg.sv
// Shared constants for the RV32I decode/execute slice: widths, opcodes,
// instruction-class codes and ALU operation codes.
package rv_decode_exec_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IMM_W = 12;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;

  typedef enum logic [2:0] {
    TIPO_R     = 3'b000,
    TIPO_I_ALU = 3'b001,
    TIPO_LOAD  = 3'b010,
    TIPO_S     = 3'b011,
    TIPO_B     = 3'b100,
    TIPO_INV   = 3'b111
  } tipo_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_XOR = 4'b0010,
    ALU_SRL = 4'b0011,
    ALU_AND = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_op_e;

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/rv_decode_exec_if.sv
// Bundle of fetch/register-file/control inputs and decode/execute outputs
// exchanged between the surrounding datapath and rv_decode_exec.
interface rv_decode_exec_if;
  import rv_decode_exec_pkg::*;

  logic [31:0]      instrucao;
  logic [XLEN-1:0]  readdata1R;
  logic [XLEN-1:0]  readdata2R;
  logic [3:0]       alucontrol;
  logic             alusrc;
  logic             branch;

  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [IMM_W-1:0] immediate;
  logic [2:0]       tipo;
  logic [XLEN-1:0]  aluresult1;
  logic [XLEN-1:0]  aluresult2;
  logic             pcsrc;

  modport master (
    output instrucao, readdata1R, readdata2R, alucontrol, alusrc, branch,
    input  opcode, rd, rs1, rs2, funct3, funct7, immediate, tipo,
           aluresult1, aluresult2, pcsrc
  );

  modport slave (
    input  instrucao, readdata1R, readdata2R, alucontrol, alusrc, branch,
    output opcode, rd, rs1, rs2, funct3, funct7, immediate, tipo,
           aluresult1, aluresult2, pcsrc
  );
endinterface

// File: rtl/rv_decode_exec_alu_core.sv
// Combinational execute logic: operand-B mux, ALU, rs1-rs2 compare and
// branch decision.
module rv_alu_core
  import rv_decode_exec_pkg::*;
(
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  reg_b,
  input  logic [IMM_W-1:0] imm,
  input  logic             alusrc,
  input  logic [3:0]       alucontrol,
  input  logic             branch,
  output logic [XLEN-1:0]  result,
  output logic [XLEN-1:0]  cmp_diff,
  output logic             take_branch
);

  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;

  always_comb begin
    op_b  = alusrc ? sext_imm(imm) : reg_b;
    shamt = op_b[4:0];
  end

  always_comb begin
    result = '0;
    case (alucontrol)
      ALU_ADD: result = op_a + op_b;
      ALU_SUB: result = op_a - op_b;
      ALU_XOR: result = op_a ^ op_b;
      ALU_SRL: result = op_a >> shamt;
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_SLL: result = op_a << shamt;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: result = '0;
    endcase
  end

  // Compare path always uses the register operand, never the immediate.
  always_comb begin
    cmp_diff    = op_a - reg_b;
    take_branch = branch & (op_a == reg_b);
  end

endmodule

// File: rtl/rv_decode_exec.sv
// Decode + execute slice: registers instruction fields/immediate, then
// registers the ALU result, compare value and branch select one edge later.
module rv_decode_exec
  import rv_decode_exec_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  rv_decode_exec_if.slave bus
);

  logic [6:0]       opcode_d, opcode_q;
  logic [4:0]       rd_d, rd_q;
  logic [4:0]       rs1_d, rs1_q;
  logic [4:0]       rs2_d, rs2_q;
  logic [2:0]       funct3_d, funct3_q;
  logic [6:0]       funct7_d, funct7_q;
  logic [IMM_W-1:0] immediate_d, immediate_q;
  tipo_e            tipo_d, tipo_q;

  logic [XLEN-1:0]  aluresult1_d, aluresult1_q;
  logic [XLEN-1:0]  aluresult2_d, aluresult2_q;
  logic             pcsrc_d, pcsrc_q;

  logic [31:0]      instr;

  always_comb begin
    instr       = bus.instrucao;
    opcode_d    = instr[6:0];
    rd_d        = instr[11:7];
    rs1_d       = instr[19:15];
    rs2_d       = instr[24:20];
    funct3_d    = instr[14:12];
    funct7_d    = instr[31:25];
    tipo_d      = TIPO_INV;
    immediate_d = '0;
    case (instr[6:0])
      OPC_R: tipo_d = TIPO_R;
      OPC_I_ALU: begin
        tipo_d      = TIPO_I_ALU;
        immediate_d = instr[31:20];
      end
      OPC_LOAD: begin
        tipo_d      = TIPO_LOAD;
        immediate_d = instr[31:20];
      end
      OPC_S: begin
        tipo_d      = TIPO_S;
        immediate_d = {instr[31:25], instr[11:7]};
      end
      OPC_B: begin
        tipo_d      = TIPO_B;
        immediate_d = {instr[31], instr[7], instr[30:25], instr[11:8]};
      end
      default: begin
        tipo_d      = TIPO_INV;
        immediate_d = '0;
      end
    endcase
  end

  // Execute consumes the already-registered immediate, giving 2-cycle
  // instrucao-to-result latency.
  rv_alu_core u_alu (
    .op_a        (bus.readdata1R),
    .reg_b       (bus.readdata2R),
    .imm         (immediate_q),
    .alusrc      (bus.alusrc),
    .alucontrol  (bus.alucontrol),
    .branch      (bus.branch),
    .result      (aluresult2_d),
    .cmp_diff    (aluresult1_d),
    .take_branch (pcsrc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q     <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      funct3_q     <= '0;
      funct7_q     <= '0;
      immediate_q  <= '0;
      tipo_q       <= TIPO_INV;
      aluresult1_q <= '0;
      aluresult2_q <= '0;
      pcsrc_q      <= 1'b0;
    end else begin
      opcode_q     <= opcode_d;
      rd_q         <= rd_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      funct3_q     <= funct3_d;
      funct7_q     <= funct7_d;
      immediate_q  <= immediate_d;
      tipo_q       <= tipo_d;
      aluresult1_q <= aluresult1_d;
      aluresult2_q <= aluresult2_d;
      pcsrc_q      <= pcsrc_d;
    end
  end

  always_comb begin
    bus.opcode     = opcode_q;
    bus.rd         = rd_q;
    bus.rs1        = rs1_q;
    bus.rs2        = rs2_q;
    bus.funct3     = funct3_q;
    bus.funct7     = funct7_q;
    bus.immediate  = immediate_q;
    bus.tipo       = tipo_q;
    bus.aluresult1 = aluresult1_q;
    bus.aluresult2 = aluresult2_q;
    bus.pcsrc      = pcsrc_q;
  end

endmodule

// File: tb/tb_rv_decode_exec.sv
// Directed self-checking bench for rv_decode_exec with hand-computed vectors.
module tb_rv_decode_exec;

  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_fail;

  rv_decode_exec_if bus ();

  rv_decode_exec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Drive one instruction plus execute-side operands, then advance two edges
  // so both decode and execute results are visible at the following negedge.
  task automatic run(input logic [31:0] instr, input logic [3:0] aluc, input logic asrc,
                     input logic br, input logic [31:0] d1, input logic [31:0] d2);
    @(negedge clk);
    bus.instrucao  = instr;
    bus.alucontrol = aluc;
    bus.alusrc     = asrc;
    bus.branch     = br;
    bus.readdata1R = d1;
    bus.readdata2R = d2;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n          = 1'b0;
    bus.instrucao  = '0;
    bus.alucontrol = '0;
    bus.alusrc     = 1'b0;
    bus.branch     = 1'b0;
    bus.readdata1R = '0;
    bus.readdata2R = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_tipo", {29'd0, bus.tipo}, 32'h7);
    check("rst_opcode", {25'd0, bus.opcode}, 32'h0);
    check("rst_aluresult2", bus.aluresult2, 32'h0);
    check("rst_pcsrc", {31'd0, bus.pcsrc}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // sub x3,x1,x2
    run(32'h402081B3, 4'b0001, 1'b0, 1'b0, 32'd10, 32'd3);
    check("sub_tipo", {29'd0, bus.tipo}, 32'h0);
    check("sub_rd", {27'd0, bus.rd}, 32'd3);
    check("sub_rs1", {27'd0, bus.rs1}, 32'd1);
    check("sub_rs2", {27'd0, bus.rs2}, 32'd2);
    check("sub_funct7", {25'd0, bus.funct7}, 32'h20);
    check("sub_imm", {20'd0, bus.immediate}, 32'h0);
    check("sub_result", bus.aluresult2, 32'd7);
    check("sub_cmp", bus.aluresult1, 32'd7);

    // addi x5,x0,-1
    run(32'hFFF00293, 4'b0000, 1'b1, 1'b0, 32'd0, 32'd0);
    check("addi_tipo", {29'd0, bus.tipo}, 32'h1);
    check("addi_imm", {20'd0, bus.immediate}, 32'hFFF);
    check("addi_result", bus.aluresult2, 32'hFFFFFFFF);

    // sw x2,4(x1)
    run(32'h0020A223, 4'b0000, 1'b1, 1'b0, 32'h100, 32'h55);
    check("sw_tipo", {29'd0, bus.tipo}, 32'h3);
    check("sw_imm", {20'd0, bus.immediate}, 32'h004);
    check("sw_result", bus.aluresult2, 32'h104);

    // beq x1,x2,+8 taken then not taken
    run(32'h00208463, 4'b0001, 1'b0, 1'b1, 32'd5, 32'd5);
    check("beq_tipo", {29'd0, bus.tipo}, 32'h4);
    check("beq_imm", {20'd0, bus.immediate}, 32'h004);
    check("beq_cmp", bus.aluresult1, 32'h0);
    check("beq_taken", {31'd0, bus.pcsrc}, 32'h1);
    run(32'h00208463, 4'b0001, 1'b0, 1'b1, 32'd5, 32'd6);
    check("beq_cmp_ne", bus.aluresult1, 32'hFFFFFFFF);
    check("beq_not_taken", {31'd0, bus.pcsrc}, 32'h0);
    run(32'h00208463, 4'b0001, 1'b0, 1'b0, 32'd5, 32'd5);
    check("beq_no_branch", {31'd0, bus.pcsrc}, 32'h0);

    // srl / xor / other ops
    run(32'h0020D233, 4'b0011, 1'b0, 1'b0, 32'h80000000, 32'd31);
    check("srl_result", bus.aluresult2, 32'h1);
    check("srl_funct3", {29'd0, bus.funct3}, 32'h5);
    run(32'h0020C233, 4'b0010, 1'b0, 1'b0, 32'h0000F0F0, 32'h0000FFFF);
    check("xor_result", bus.aluresult2, 32'h00000F0F);
    run(32'h0020C233, 4'b0110, 1'b0, 1'b0, 32'h12345678, 32'd32);
    check("sll_by32", bus.aluresult2, 32'h12345678);
    run(32'h0020C233, 4'b0011, 1'b0, 1'b0, 32'hABCD0000, 32'd0);
    check("srl_by0", bus.aluresult2, 32'hABCD0000);
    run(32'h0020C233, 4'b0111, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1);
    check("slt_signed", bus.aluresult2, 32'h1);
    run(32'h0020C233, 4'b0100, 1'b0, 1'b0, 32'hFF00FF00, 32'h0FF00FF0);
    check("and_result", bus.aluresult2, 32'h0F000F00);
    run(32'h0020C233, 4'b0101, 1'b0, 1'b0, 32'hFF000000, 32'h000000FF);
    check("or_result", bus.aluresult2, 32'hFF0000FF);
    run(32'h0020C233, 4'b1010, 1'b0, 1'b0, 32'h11111111, 32'h2);
    check("op_1xxx_zero", bus.aluresult2, 32'h0);
    run(32'h0FF0A083, 4'b0000, 1'b1, 1'b0, 32'h1000, 32'h0);
    check("lw_tipo", {29'd0, bus.tipo}, 32'h2);
    check("lw_result", bus.aluresult2, 32'h10FF);

    // mid-stream async reset
    @(negedge clk);
    bus.instrucao  = 32'h402081B3;
    bus.alucontrol = 4'b0001;
    bus.alusrc     = 1'b0;
    bus.readdata1R = 32'd9;
    bus.readdata2R = 32'd9;
    bus.branch     = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tipo", {29'd0, bus.tipo}, 32'h7);
    check("midrst_rd", {27'd0, bus.rd}, 32'h0);
    check("midrst_result", bus.aluresult2, 32'h0);
    check("midrst_pcsrc", {31'd0, bus.pcsrc}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // undefined opcode
    run(32'h0000007F, 4'b0000, 1'b1, 1'b0, 32'h20, 32'h0);
    check("undef_tipo", {29'd0, bus.tipo}, 32'h7);
    check("undef_imm", {20'd0, bus.immediate}, 32'h0);
    check("undef_opcode", {25'd0, bus.opcode}, 32'h7F);
    check("undef_result", bus.aluresult2, 32'h20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
